// File: rtl/dec8b10b_lanes.sv
// Multi-lane 8b/10b decoder: RD chained lane 0 -> LANES-1, code/disparity errors, commas, saturating error count.
// Latency PIPE_IN+1 cycles from in_valid to out_valid; no backpressure, flags hold while idle.
module dec8b10b_lanes #(
    parameter int LANES     = 2,
    parameter int PIPE_IN   = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  in_valid,
    input  logic [10*LANES-1:0]   data_in,
    input  logic                  clr_cnt,
    output logic                  out_valid,
    output logic [8*LANES-1:0]    data_out,
    output logic [LANES-1:0]      k_out,
    output logic [LANES-1:0]      code_err,
    output logic [LANES-1:0]      disp_err,
    output logic [LANES-1:0]      comma,
    output logic                  rd_out,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    typedef struct packed {
        logic       ok;
        logic       k;
        logic [7:0] dat;
    } dec_t;

    typedef struct packed {
        logic       ce;
        logic       de;
        logic       k;
        logic       comma;
        logic [7:0] dat;
        logic       rd_end;
    } lane_t;

    // Sub-blocks are held a-first: six = {a,b,c,d,e,i}, four = {f,g,h,j}.
    function automatic logic [5:0] sym_six(input logic [9:0] s);
        return {s[0], s[1], s[2], s[3], s[4], s[5]};
    endfunction

    function automatic logic [3:0] sym_four(input logic [9:0] s);
        return {s[6], s[7], s[8], s[9]};
    endfunction

    function automatic logic rd_after6(input logic [5:0] s, input logic rd);
        logic [2:0] ones;
        ones = 3'($countones(s));
        if (ones > 3'd3)          return 1'b1;
        else if (ones < 3'd3)     return 1'b0;
        else if (s == 6'b000111)  return 1'b1;
        else if (s == 6'b111000)  return 1'b0;
        else                      return rd;
    endfunction

    function automatic logic rd_after4(input logic [3:0] f, input logic rd);
        logic [2:0] ones;
        ones = 3'($countones(f));
        if (ones > 3'd2)          return 1'b1;
        else if (ones < 3'd2)     return 1'b0;
        else if (f == 4'b0011)    return 1'b1;
        else if (f == 4'b1100)    return 1'b0;
        else                      return rd;
    endfunction

    // Decode assuming the symbol starts at disparity rd; ok only if legal in that column.
    function automatic dec_t decode_sym(input logic [9:0] sym, input logic rd);
        logic [5:0] six;
        logic [3:0] four;
        logic [4:0] x;
        logic [1:0] col;
        logic       k28, kx, rd6, ok4, kk;
        logic [2:0] y;
        dec_t       r;
        six  = sym_six(sym);
        four = sym_four(sym);
        k28  = 1'b0;
        case (six)
            6'b100111: {x, col} = {5'd0,  2'b10};
            6'b011000: {x, col} = {5'd0,  2'b01};
            6'b011101: {x, col} = {5'd1,  2'b10};
            6'b100010: {x, col} = {5'd1,  2'b01};
            6'b101101: {x, col} = {5'd2,  2'b10};
            6'b010010: {x, col} = {5'd2,  2'b01};
            6'b110001: {x, col} = {5'd3,  2'b11};
            6'b110101: {x, col} = {5'd4,  2'b10};
            6'b001010: {x, col} = {5'd4,  2'b01};
            6'b101001: {x, col} = {5'd5,  2'b11};
            6'b011001: {x, col} = {5'd6,  2'b11};
            6'b111000: {x, col} = {5'd7,  2'b10};
            6'b000111: {x, col} = {5'd7,  2'b01};
            6'b111001: {x, col} = {5'd8,  2'b10};
            6'b000110: {x, col} = {5'd8,  2'b01};
            6'b100101: {x, col} = {5'd9,  2'b11};
            6'b010101: {x, col} = {5'd10, 2'b11};
            6'b110100: {x, col} = {5'd11, 2'b11};
            6'b001101: {x, col} = {5'd12, 2'b11};
            6'b101100: {x, col} = {5'd13, 2'b11};
            6'b011100: {x, col} = {5'd14, 2'b11};
            6'b010111: {x, col} = {5'd15, 2'b10};
            6'b101000: {x, col} = {5'd15, 2'b01};
            6'b011011: {x, col} = {5'd16, 2'b10};
            6'b100100: {x, col} = {5'd16, 2'b01};
            6'b100011: {x, col} = {5'd17, 2'b11};
            6'b010011: {x, col} = {5'd18, 2'b11};
            6'b110010: {x, col} = {5'd19, 2'b11};
            6'b001011: {x, col} = {5'd20, 2'b11};
            6'b101010: {x, col} = {5'd21, 2'b11};
            6'b011010: {x, col} = {5'd22, 2'b11};
            6'b111010: {x, col} = {5'd23, 2'b10};
            6'b000101: {x, col} = {5'd23, 2'b01};
            6'b110011: {x, col} = {5'd24, 2'b10};
            6'b001100: {x, col} = {5'd24, 2'b01};
            6'b100110: {x, col} = {5'd25, 2'b11};
            6'b010110: {x, col} = {5'd26, 2'b11};
            6'b110110: {x, col} = {5'd27, 2'b10};
            6'b001001: {x, col} = {5'd27, 2'b01};
            6'b001110: {x, col} = {5'd28, 2'b11};
            6'b101110: {x, col} = {5'd29, 2'b10};
            6'b010001: {x, col} = {5'd29, 2'b01};
            6'b011110: {x, col} = {5'd30, 2'b10};
            6'b100001: {x, col} = {5'd30, 2'b01};
            6'b101011: {x, col} = {5'd31, 2'b10};
            6'b010100: {x, col} = {5'd31, 2'b01};
            6'b001111: begin {x, col} = {5'd28, 2'b10}; k28 = 1'b1; end
            6'b110000: begin {x, col} = {5'd28, 2'b01}; k28 = 1'b1; end
            default:   {x, col} = {5'd0, 2'b00};
        endcase
        rd6 = rd_after6(six, rd);
        kx  = x inside {5'd23, 5'd27, 5'd29, 5'd30};
        kk  = k28;
        y   = 3'd0;
        ok4 = 1'b0;
        // 4b codes are keyed on the disparity entering the 4b sub-block.
        if (k28) begin
            if (rd6) begin
                case (four)
                    4'b0100: {y, ok4} = {3'd0, 1'b1};
                    4'b1001: {y, ok4} = {3'd1, 1'b1};
                    4'b0101: {y, ok4} = {3'd2, 1'b1};
                    4'b0011: {y, ok4} = {3'd3, 1'b1};
                    4'b0010: {y, ok4} = {3'd4, 1'b1};
                    4'b1010: {y, ok4} = {3'd5, 1'b1};
                    4'b0110: {y, ok4} = {3'd6, 1'b1};
                    4'b1000: {y, ok4} = {3'd7, 1'b1};
                    default: {y, ok4} = {3'd0, 1'b0};
                endcase
            end else begin
                case (four)
                    4'b1011: {y, ok4} = {3'd0, 1'b1};
                    4'b0110: {y, ok4} = {3'd1, 1'b1};
                    4'b1010: {y, ok4} = {3'd2, 1'b1};
                    4'b1100: {y, ok4} = {3'd3, 1'b1};
                    4'b1101: {y, ok4} = {3'd4, 1'b1};
                    4'b0101: {y, ok4} = {3'd5, 1'b1};
                    4'b1001: {y, ok4} = {3'd6, 1'b1};
                    4'b0111: {y, ok4} = {3'd7, 1'b1};
                    default: {y, ok4} = {3'd0, 1'b0};
                endcase
            end
        end else if (!rd6) begin
            case (four)
                4'b1011: {y, ok4} = {3'd0, 1'b1};
                4'b1001: {y, ok4} = {3'd1, 1'b1};
                4'b0101: {y, ok4} = {3'd2, 1'b1};
                4'b1100: {y, ok4} = {3'd3, 1'b1};
                4'b1101: {y, ok4} = {3'd4, 1'b1};
                4'b1010: {y, ok4} = {3'd5, 1'b1};
                4'b0110: {y, ok4} = {3'd6, 1'b1};
                4'b1110: {y, ok4} = {3'd7, 1'b1};
                4'b0111: begin
                    y   = 3'd7;
                    ok4 = kx || (x inside {5'd17, 5'd18, 5'd20});
                    kk  = kx;
                end
                default: {y, ok4} = {3'd0, 1'b0};
            endcase
        end else begin
            case (four)
                4'b0100: {y, ok4} = {3'd0, 1'b1};
                4'b1001: {y, ok4} = {3'd1, 1'b1};
                4'b0101: {y, ok4} = {3'd2, 1'b1};
                4'b0011: {y, ok4} = {3'd3, 1'b1};
                4'b0010: {y, ok4} = {3'd4, 1'b1};
                4'b1010: {y, ok4} = {3'd5, 1'b1};
                4'b0110: {y, ok4} = {3'd6, 1'b1};
                4'b0001: {y, ok4} = {3'd7, 1'b1};
                4'b1000: begin
                    y   = 3'd7;
                    ok4 = kx || (x inside {5'd11, 5'd13, 5'd14});
                    kk  = kx;
                end
                default: {y, ok4} = {3'd0, 1'b0};
            endcase
        end
        r.ok  = (rd ? col[0] : col[1]) && ok4;
        r.k   = kk;
        r.dat = {y, x};
        return r;
    endfunction

    function automatic lane_t lane_dec(input logic [9:0] sym, input logic rd);
        dec_t  dn, dp, dsel;
        lane_t r;
        dn      = decode_sym(sym, 1'b0);
        dp      = decode_sym(sym, 1'b1);
        dsel    = dn.ok ? dn : dp;
        r.ce    = !dn.ok && !dp.ok;
        r.de    = !r.ce && !(rd ? dp.ok : dn.ok);
        r.k     = !r.ce && dsel.k;
        r.dat   = r.ce ? 8'h00 : dsel.dat;
        r.comma = r.k && (dsel.dat[4:0] == 5'd28) &&
                  (dsel.dat[7:5] inside {3'd1, 3'd5, 3'd7});
        // Error symbols still move RD so the checker follows the line.
        r.rd_end = rd_after4(sym_four(sym), rd_after6(sym_six(sym), rd));
        return r;
    endfunction

    logic                 dec_vld;
    logic [10*LANES-1:0]  dec_dat;

    generate
        if (PIPE_IN != 0) begin : g_pipe
            logic                vld_q;
            logic [10*LANES-1:0] dat_q;
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    vld_q <= 1'b0;
                    dat_q <= '0;
                end else begin
                    vld_q <= in_valid;
                    if (in_valid) dat_q <= data_in;
                end
            end
            assign dec_vld = vld_q;
            assign dec_dat = dat_q;
        end else begin : g_direct
            assign dec_vld = in_valid;
            assign dec_dat = data_in;
        end
    endgenerate

    logic [8*LANES-1:0] data_d;
    logic [LANES-1:0]   k_d, ce_d, de_d, comma_d;
    logic               rd_d;

    always_comb begin
        lane_t res;
        logic  rd_run;
        data_d  = '0;
        k_d     = '0;
        ce_d    = '0;
        de_d    = '0;
        comma_d = '0;
        rd_run  = rd_out;
        for (int n = 0; n < LANES; n++) begin
            res             = lane_dec(dec_dat[10*n +: 10], rd_run);
            data_d[8*n +: 8] = res.dat;
            k_d[n]          = res.k;
            ce_d[n]         = res.ce;
            de_d[n]         = res.de;
            comma_d[n]      = res.comma;
            rd_run          = res.rd_end;
        end
        rd_d = rd_run;
    end

    logic [8*LANES-1:0]   data_q;
    logic [LANES-1:0]     k_q, ce_q, de_q, comma_q;
    logic                 vld_q, rd_q;
    logic [ERR_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            k_q     <= '0;
            ce_q    <= '0;
            de_q    <= '0;
            comma_q <= '0;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            vld_q <= dec_vld;
            if (dec_vld) begin
                data_q  <= data_d;
                k_q     <= k_d;
                ce_q    <= ce_d;
                de_q    <= de_d;
                comma_q <= comma_d;
                rd_q    <= rd_d;
            end
            if (clr_cnt)
                cnt_q <= '0;
            else if (dec_vld && |(ce_d | de_d) && (cnt_q != {ERR_CNT_W{1'b1}}))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid = vld_q;
    assign data_out  = data_q;
    assign k_out     = k_q;
    assign code_err  = ce_q;
    assign disp_err  = de_q;
    assign comma     = comma_q;
    assign rd_out    = rd_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_dec8b10b_lanes.sv
// Directed bench for dec8b10b_lanes (2 lanes, input pipe, 2-bit error counter).
module tb_dec8b10b_lanes;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        in_valid;
    logic [19:0] data_in;
    logic        clr_cnt;
    logic        out_valid;
    logic [15:0] data_out;
    logic [1:0]  k_out, code_err, disp_err, comma;
    logic        rd_out;
    logic [1:0]  err_cnt;

    int n_chk = 0;
    int n_err = 0;

    dec8b10b_lanes #(.LANES(2), .PIPE_IN(1), .ERR_CNT_W(2)) dut (
        .clk(clk), .reset_L(reset_L), .in_valid(in_valid), .data_in(data_in),
        .clr_cnt(clr_cnt), .out_valid(out_valid), .data_out(data_out), .k_out(k_out),
        .code_err(code_err), .disp_err(disp_err), .comma(comma), .rd_out(rd_out),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  l0, l1;
        logic        clr;
        logic [15:0] dat;
        logic [1:0]  k, ce, de, cm;
        logic        rd;
        logic [1:0]  cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic v[6];
        //          lane0    lane1    clr   data      k      ce     de     comma  rd    cnt
        vecs[0]  = '{10'h17C, 10'h283, 1'b0, 16'hBCBC, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0, 2'd0};
        vecs[1]  = '{10'h0B9, 10'h155, 1'b0, 16'hB500, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0};
        vecs[2]  = '{10'h283, 10'h17C, 1'b0, 16'hBCBC, 2'b11, 2'b00, 2'b01, 2'b11, 1'b1, 2'd1};
        vecs[3]  = '{10'h3FF, 10'h283, 1'b0, 16'hBC00, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0, 2'd2};
        vecs[4]  = '{10'h3FF, 10'h000, 1'b0, 16'h0000, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 2'd3};
        vecs[5]  = '{10'h283, 10'h0B9, 1'b0, 16'h00BC, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 2'd3};
        vecs[6]  = '{10'h3FF, 10'h17C, 1'b1, 16'hBC00, 2'b10, 2'b01, 2'b10, 2'b10, 1'b1, 2'd0};
        vecs[7]  = '{10'h04B, 10'h057, 1'b0, 16'hF7EB, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2'd0};
        vecs[8]  = '{10'h07C, 10'h3B1, 1'b0, 16'hF1FC, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 2'd0};
        vecs[9]  = '{10'h231, 10'h27C, 1'b0, 16'h3CF1, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 2'd0};
        vecs[10] = '{10'h386, 10'h0A3, 1'b0, 16'h0300, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 2'd1};

        reset_L  = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        clr_cnt  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset data_out",  32'(data_out),  32'h0);
        chk("reset flags",     32'({k_out, code_err, disp_err, comma}), 32'h0);
        chk("reset rd_out",    32'(rd_out),    32'h0);
        chk("reset err_cnt",   32'(err_cnt),   32'h0);
        reset_L = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            data_in  = {vecs[i].l1, vecs[i].l0};
            in_valid = 1'b1;
            clr_cnt  = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d latency", i), 32'(out_valid), 32'h0);
            in_valid = 1'b0;
            clr_cnt  = vecs[i].clr;
            @(negedge clk);
            clr_cnt = 1'b0;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'h1);
            chk($sformatf("v%0d data_out", i),  32'(data_out),  32'(vecs[i].dat));
            chk($sformatf("v%0d k_out", i),     32'(k_out),     32'(vecs[i].k));
            chk($sformatf("v%0d code_err", i),  32'(code_err),  32'(vecs[i].ce));
            chk($sformatf("v%0d disp_err", i),  32'(disp_err),  32'(vecs[i].de));
            chk($sformatf("v%0d comma", i),     32'(comma),     32'(vecs[i].cm));
            chk($sformatf("v%0d rd_out", i),    32'(rd_out),    32'(vecs[i].rd));
            chk($sformatf("v%0d err_cnt", i),   32'(err_cnt),   32'(vecs[i].cnt));
        end

        // Idle cycle: outputs hold, valid drops.
        @(negedge clk);
        chk("idle out_valid", 32'(out_valid), 32'h0);
        chk("idle data hold", 32'(data_out),  32'h0300);
        chk("idle code hold", 32'(code_err),  32'h1);
        chk("idle rd hold",   32'(rd_out),    32'h0);

        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        chk("clr idle err_cnt", 32'(err_cnt), 32'h0);

        // Back-to-back error cycles saturate the 2-bit counter.
        for (int k = 0; k < 7; k++) begin
            if (k >= 2) begin
                chk($sformatf("sat%0d out_valid", k), 32'(out_valid), 32'h1);
                chk($sformatf("sat%0d err_cnt", k),   32'(err_cnt),   (k - 1 > 3) ? 32'd3 : 32'(k - 1));
            end
            data_in  = {10'h3FF, 10'h3FF};
            in_valid = 1'b1;
            @(negedge clk);
        end

        // Asynchronous reset mid-burst.
        #2 reset_L = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 32'h0);
        chk("arst err_cnt",   32'(err_cnt),   32'h0);
        chk("arst code_err",  32'(code_err),  32'h0);
        chk("arst rd_out",    32'(rd_out),    32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        reset_L  = 1'b1;
        @(negedge clk);
        chk("arst flush v1", 32'(out_valid), 32'h0);
        @(negedge clk);
        chk("arst flush v2", 32'(out_valid), 32'h0);

        // Alternating valid/idle with K28.5- in lane 0, D21.5 in lane 1.
        v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        data_in = {10'h155, 10'h17C};
        for (int k = 0; k < 6; k++) begin
            if (k >= 2) begin
                chk($sformatf("alt%0d out_valid", k), 32'(out_valid), 32'(v[k-2]));
                chk($sformatf("alt%0d rd_out", k),    32'(rd_out),    32'h1);
                chk($sformatf("alt%0d data_out", k),  32'(data_out),  32'hB5BC);
                chk($sformatf("alt%0d disp_err", k),  32'(disp_err),  (k >= 4) ? 32'h1 : 32'h0);
                chk($sformatf("alt%0d err_cnt", k),   32'(err_cnt),   (k >= 4) ? 32'h1 : 32'h0);
            end
            in_valid = v[k];
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dec8b10b_lanes.md
Name: dec8b10b_lanes

Overview:
- Parametrised multi-lane 8b/10b decoder with running-disparity (RD) tracking, code/disparity error detection, comma flagging and a saturating error counter.
- Sits behind the deserialiser; successor to the single-lane 10-to-8 decoder.
- Adds lane count, a valid handshake, an optional input pipeline stage and true stateful disparity checking.

Parameters:
- LANES, 2, number of 10-bit symbols decoded per cycle; lane 0 is earliest in time.
- PIPE_IN, 1, 1 = register inputs before decode; 0 = decode directly from ports.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- in_valid  in  1  data_in carries symbols this cycle.
- data_in  in  10*LANES  lane n at [10n+9:10n], bit order j h g f i e d c b a (bit9..bit0).
- clr_cnt  in  1  synchronous clear of err_cnt.
- out_valid  out  1  outputs carry decoded lanes.
- data_out  out  8*LANES  lane n at [8n+7:8n] = H G F E D C B A.
- k_out  out  LANES  control symbol decoded.
- code_err  out  LANES  symbol not in 8b/10b table for either RD.
- disp_err  out  LANES  valid symbol, wrong RD column.
- comma  out  LANES  symbol is K28.1, K28.5 or K28.7.
- rd_out  out  1  current RD register (0 = negative, 1 = positive).
- err_cnt  out  ERR_CNT_W  count of valid cycles with any code_err or disp_err.

Behaviour:
- Reset (async, reset_L=0): all outputs 0, RD = 0 (negative), input pipeline valid cleared. Reset mid-stream discards in-flight symbols.
- Latency: out_valid asserts PIPE_IN+1 cycles after in_valid. All outputs are registered.
- in_valid=0: nothing decoded, RD held. out_valid drops to 0 and data/flag outputs hold their last values. No backpressure exists.
- Decode table: IEEE 802.3 cl.36 5b/6b + 3b/4b, all 256 D codes and 12 K codes (K28.0-7, K23.7, K27.7, K29.7, K30.7).
  - The K vs D.x.7 alternate (A7) forms are decoded.
  - The primary D.x.7 form is accepted in either RD.
- RD chaining: lane 0 is checked against the RD register. Lane n is checked against the ending RD of lane n-1. The RD register takes the ending RD of lane LANES-1.
- Ending RD per sub-block, applied abcdei first, then fghj:
  - more ones than zeros, or 000111 (a..i) / 0011 (f..j) -> positive;
  - more zeros than ones, or 111000 / 1100 -> negative;
  - otherwise unchanged.
  - This rule also applies to error symbols, so RD resynchronises to the received stream.
- Error flag precedence:
  - code_err set -> disp_err forced 0, data_out = 0x00, k_out = 0.
  - disp_err set -> data_out/k_out still give the decoded value.
- err_cnt:
  - increments by 1 per out_valid cycle in which any lane flags an error (not per lane);
  - saturates at 2^ERR_CNT_W-1;
  - clr_cnt wins over a simultaneous increment (result 0).
- comma is asserted in both RD columns and is independent of disp_err.

Test Plan:
- LANES=2, PIPE_IN=1: after reset, data_in={0x283,0x17C}, in_valid=1 for 1 cycle -> 2 cycles later:
  - out_valid=1, data_out=0xBCBC, k_out=2'b11, comma=2'b11, code_err=disp_err=0;
  - rd_out=0 (lane0 K28.5- ends +, lane1 K28.5+ ends -).
- From RD-: lane0=0x0B9 (D0.0-), lane1=0x155 (D21.5) -> data_out=0xB500, no errors, rd_out=0, k_out=0.
- From RD-: lane0=0x283 (K28.5+) -> disp_err[0]=1, data=0xBC, k_out[0]=1, err_cnt=1. Lane1=0x17C is then checked against RD- and is clean.
- lane0=0x3FF -> code_err[0]=1, disp_err[0]=0, data byte 0x00, RD after lane0 = +. Lane1=0x283 is then clean.
- ERR_CNT_W=2: 5 consecutive error cycles -> err_cnt 1,2,3,3,3. clr_cnt on an error cycle -> 0. Pulse reset_L low mid-burst -> outputs 0 immediately, rd_out=0.
- in_valid gaps: alternate valid/idle with 0x17C in lane0 -> RD held across idles, out_valid toggles with the same latency, outputs hold during idles.
